// File: rtl/acsi_data_fifo_pkg.sv
// Shared ACSI data-path constants: transfer direction encoding and default FIFO size.
// Imported by the data FIFO and by the hdd bus-interface block.
package acsi_data_fifo_pkg;

  localparam logic ACSI_DIR_ATARI_TO_AVR = 1'b0;
  localparam logic ACSI_DIR_AVR_TO_ATARI = 1'b1;
  localparam int   FIFO_DEPTH_LOG2       = 4;

  typedef struct packed {
    logic       push;
    logic       pop;
    logic [7:0] dat;
  } fifo_req_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous strobe plus a rising-edge pulse.
// rise_o is a one-cycle pulse in the clock cycle after the second flop goes high.
module sync_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  // [0],[1] form the synchroniser; [2] remembers the previous synchronised level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_i};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/acsi_data_fifo.sv
// Direction-switched byte FIFO between the ACSI bus interface and the AVR byte port.
// dir=0: ACSI pushes, AVR pops; dir=1: AVR pushes, ACSI pops. A direction change flushes.
module acsi_data_fifo
  import acsi_data_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dir,
  input  logic                  flush,
  input  logic                  acsi_wr_stb,
  input  logic [7:0]            acsi_wr_data,
  input  logic                  acsi_rd_stb,
  input  logic                  a_cs,
  input  logic [7:0]            a_data_in,
  output logic [7:0]            head_data,
  output logic                  not_empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  a_int,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [DEPTH_LOG2:0]   DEPTH_C  = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   AF_LEVEL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2 - AF_MARGIN);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  dir_q;
  logic                  a_rise, clear, push_ok, pop_ok;
  fifo_req_t             req;

  sync_rise_detect u_a_cs_rise (
    .clock   (clock),
    .reset   (reset),
    .async_i (a_cs),
    .rise_o  (a_rise)
  );

  // A direction change acts as a flush and swallows that cycle's strobes
  assign clear    = flush | (dir != dir_q);
  assign req.push = (dir_q == ACSI_DIR_AVR_TO_ATARI) ? a_rise      : acsi_wr_stb;
  assign req.pop  = (dir_q == ACSI_DIR_AVR_TO_ATARI) ? acsi_rd_stb : a_rise;
  assign req.dat  = (dir_q == ACSI_DIR_AVR_TO_ATARI) ? a_data_in   : acsi_wr_data;

  assign pop_ok  = ~clear & req.pop  & (count_q != '0);
  assign push_ok = ~clear & req.push & ((count_q != DEPTH_C) | pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok) count_d = count_q + CNT_ONE;
      if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
      if (req.push && !push_ok) overflow_d  = 1'b1;
      if (req.pop  && !pop_ok)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dir_q       <= dir;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= req.dat;
  end

  assign head_data   = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign not_empty   = (count_q != '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_LEVEL);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  // Uses the dir pin so the AVR sees the selected direction even while reset holds dir_q
  assign a_int       = (dir == ACSI_DIR_AVR_TO_ATARI) ? ~full : not_empty;

endmodule

// File: tb/tb_acsi_data_fifo.sv
// Directed bench for acsi_data_fifo: stimulus queues expected pop bytes, a monitor checks them.
module tb_acsi_data_fifo;

  logic       clock = 1'b0;
  logic       reset, dir, flush, acsi_wr_stb, acsi_rd_stb, a_cs;
  logic [7:0] acsi_wr_data, a_data_in, head_data;
  logic       not_empty, full, almost_full, a_int, overflow, underflow;
  logic [4:0] count;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic       pop_now  = 1'b0;

  acsi_data_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .dir          (dir),
    .flush        (flush),
    .acsi_wr_stb  (acsi_wr_stb),
    .acsi_wr_data (acsi_wr_data),
    .acsi_rd_stb  (acsi_rd_stb),
    .a_cs         (a_cs),
    .a_data_in    (a_data_in),
    .head_data    (head_data),
    .not_empty    (not_empty),
    .full         (full),
    .almost_full  (almost_full),
    .count        (count),
    .a_int        (a_int),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a pop takes effect this cycle, head_data must be the oldest queued byte
  always @(negedge clock) begin
    if (pop_now && exp_q.size() != 0) begin
      chk("pop_data", {24'd0, head_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic acsi_push(input logic [7:0] b, input bit accepted);
    acsi_wr_data = b;
    acsi_wr_stb  = 1'b1;
    if (accepted) exp_q.push_back(b);
    step();
    acsi_wr_stb = 1'b0;
  endtask

  task automatic acsi_pop();
    acsi_rd_stb = 1'b1;
    pop_now     = 1'b1;
    step();
    acsi_rd_stb = 1'b0;
    pop_now     = 1'b0;
  endtask

  // AVR strobe: a_rise lands in the cycle after the second edge; optionally coincide an ACSI push
  task automatic avr_xfer(input logic [7:0] b, input bit coincide, input logic [7:0] wb,
                          input logic [4:0] exp_cnt);
    logic [4:0] c0;
    c0        = count;
    a_cs      = 1'b1;
    a_data_in = b;
    step();
    @(negedge clock);
    chk("avr_early_cnt", {27'd0, count}, {27'd0, c0});
    step();
    if (dir == 1'b0) pop_now = 1'b1;
    else exp_q.push_back(b);
    if (coincide) begin
      acsi_wr_data = wb;
      acsi_wr_stb  = 1'b1;
      exp_q.push_back(wb);
    end
    step();
    pop_now     = 1'b0;
    acsi_wr_stb = 1'b0;
    a_cs        = 1'b0;
    @(negedge clock);
    chk("avr_cnt", {27'd0, count}, {27'd0, exp_cnt});
    step();
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; dir = 1'b0; flush = 1'b0; acsi_wr_stb = 1'b0; acsi_rd_stb = 1'b0;
    a_cs = 1'b0; acsi_wr_data = 8'h00; a_data_in = 8'h00;

    // 1: reset state and a_int following dir
    #12;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_not_empty", {31'd0, not_empty}, 32'd0);
    chk("rst_a_int_dir0", {31'd0, a_int}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_almost_full", {31'd0, almost_full}, 32'd0);
    dir = 1'b1;
    #1;
    chk("rst_a_int_dir1", {31'd0, a_int}, 32'd1);
    dir = 1'b0;
    step();
    reset = 1'b0;
    step();

    // 2: two ACSI pushes, two AVR pops
    acsi_push(8'hA5, 1'b1);
    acsi_push(8'h5A, 1'b1);
    @(negedge clock);
    chk("t2_count", {27'd0, count}, 32'd2);
    chk("t2_head", {24'd0, head_data}, 32'hA5);
    chk("t2_a_int", {31'd0, a_int}, 32'd1);
    step();
    avr_xfer(8'h00, 1'b0, 8'h00, 5'd1);
    chk("t2_head2", {24'd0, head_data}, 32'h5A);
    avr_xfer(8'h00, 1'b0, 8'h00, 5'd0);
    chk("t2_not_empty", {31'd0, not_empty}, 32'd0);
    chk("t2_a_int_empty", {31'd0, a_int}, 32'd0);

    // 3: fill, thresholds, overflow, drain with wrap
    for (int i = 0; i < 16; i++) begin
      acsi_push(8'(i), 1'b1);
      @(negedge clock);
      chk("t3_almost_full", {31'd0, almost_full}, {31'd0, (i + 1 >= 14)});
      chk("t3_full", {31'd0, full}, {31'd0, (i + 1 == 16)});
      step();
    end
    acsi_push(8'h10, 1'b0);
    @(negedge clock);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_count_full", {27'd0, count}, 32'd16);
    step();
    for (int i = 0; i < 16; i++) avr_xfer(8'h00, 1'b0, 8'h00, 5'(15 - i));
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clock);
    chk("t3_flush_overflow", {31'd0, overflow}, 32'd0);
    step();

    // 4: push and pop coincide while full; then underflow in dir=1
    for (int i = 0; i < 16; i++) acsi_push(8'h20 + 8'(i), 1'b1);
    avr_xfer(8'h00, 1'b1, 8'hEE, 5'd16);
    chk("t4_no_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) avr_xfer(8'h00, 1'b0, 8'h00, 5'(15 - i));
    dir = 1'b1;
    step();
    step();
    acsi_pop();
    @(negedge clock);
    chk("t4_underflow", {31'd0, underflow}, 32'd1);
    chk("t4_a_int_dir1", {31'd0, a_int}, 32'd1);
    step();

    // 5: AVR pushes five bytes, then a direction flip with stale strobes
    for (int i = 0; i < 5; i++) avr_xfer(8'h30 + 8'(i), 1'b0, 8'h00, 5'(i + 1));
    chk("t5_head", {24'd0, head_data}, 32'h30);
    a_cs = 1'b1; a_data_in = 8'h77;
    step();
    step();
    dir = 1'b0; acsi_wr_stb = 1'b1; acsi_wr_data = 8'h99; acsi_rd_stb = 1'b1;
    exp_q.delete();
    step();
    acsi_wr_stb = 1'b0; acsi_rd_stb = 1'b0; a_cs = 1'b0;
    @(negedge clock);
    chk("t5_count", {27'd0, count}, 32'd0);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    chk("t5_underflow", {31'd0, underflow}, 32'd0);
    chk("t5_not_empty", {31'd0, not_empty}, 32'd0);
    step();
    step();
    step();

    // 6: asynchronous reset mid-burst, then resume
    for (int i = 0; i < 7; i++) acsi_push(8'h40 + 8'(i), 1'b1);
    @(negedge clock);
    chk("t6_count7", {27'd0, count}, 32'd7);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_count", {27'd0, count}, 32'd0);
    chk("t6_async_not_empty", {31'd0, not_empty}, 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    acsi_push(8'hAA, 1'b1);
    acsi_push(8'hBB, 1'b1);
    avr_xfer(8'h00, 1'b0, 8'h00, 5'd1);
    chk("t6_head", {24'd0, head_data}, 32'hBB);
    avr_xfer(8'h00, 1'b0, 8'h00, 5'd0);
    chk("t6_empty", {31'd0, not_empty}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
